// File: rtl/sdram_arb_pkg.sv
// Shared encodings and defaults for the SDRAM sequencer arbiter.
package sdram_arb_pkg;

    localparam int REF_MAX_DEF    = 7;
    localparam int REF_URGENT_DEF = 4;
    localparam int DMA_AGE_DEF    = 8;
    localparam int BUSY_TMO_DEF   = 4;
    localparam int DEBT_W         = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_BUSY,
        ST_TURN
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CPU  = 2'd1,
        SEL_DMA  = 2'd2,
        SEL_REF  = 2'd3
    } gnt_sel_t;

    // Fixed priority: urgent refresh, aged DMA, CPU, DMA, owed refresh.
    function automatic gnt_sel_t pick_winner(
        input logic ref_urgent,
        input logic dma_aged,
        input logic cpu_req,
        input logic dma_req,
        input logic ref_owed
    );
        gnt_sel_t sel;
        sel = SEL_NONE;
        if (ref_urgent)    sel = SEL_REF;
        else if (dma_aged) sel = SEL_DMA;
        else if (cpu_req)  sel = SEL_CPU;
        else if (dma_req)  sel = SEL_DMA;
        else if (ref_owed) sel = SEL_REF;
        return sel;
    endfunction

endpackage

// File: rtl/sdram_refresh_debt.sv
// Counts refreshes owed: REFRESH rising edges add one, refresh grants remove one.
module sdram_refresh_debt
    import sdram_arb_pkg::*;
#(
    parameter int REF_MAX = REF_MAX_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_refresh,
    input  logic              i_take,
    output logic [DEBT_W-1:0] o_debt,
    output logic              o_ovf
);

    logic              r_refresh_d;
    logic [DEBT_W-1:0] r_debt;
    logic              r_ovf;
    logic              w_tick;
    logic              w_take;
    logic              w_at_max;

    assign w_tick   = i_refresh & ~r_refresh_d;
    assign w_take   = i_take & (r_debt != '0);
    assign w_at_max = (r_debt == DEBT_W'(REF_MAX));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_refresh_d <= 1'b0;
            r_debt      <= DEBT_W'(1);
            r_ovf       <= 1'b0;
        end else begin
            r_refresh_d <= i_refresh;
            // A tick and a grant in the same cycle cancel out.
            if (w_tick && !w_take) begin
                if (w_at_max) r_ovf  <= 1'b1;
                else          r_debt <= r_debt + 1'b1;
            end else if (w_take && !w_tick) begin
                r_debt <= r_debt - 1'b1;
            end
        end
    end

    assign o_debt = r_debt;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/sdram_arbiter.sv
// Grants the SDRAM sequencer to CPU, DMA master or auto-refresh, one cycle at a time.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int REF_MAX    = REF_MAX_DEF,
    parameter int REF_URGENT = REF_URGENT_DEF,
    parameter int DMA_AGE    = DMA_AGE_DEF,
    parameter int BUSY_TMO   = BUSY_TMO_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REFRESH,
    input  logic              CPU_REQ,
    input  logic              DMA_REQ,
    input  logic              SEQ_BUSY,
    output logic              START,
    output logic              GNT_CPU,
    output logic              GNT_DMA,
    output logic              GNT_REF,
    output logic [DEBT_W-1:0] REF_DEBT,
    output logic              REF_OVF,
    output logic              TMO_ERR
);

    localparam int AGE_W  = $clog2(DMA_AGE + 1);
    localparam int WAIT_W = $clog2(BUSY_TMO + 1);

    state_t            r_state;
    gnt_sel_t          r_sel;
    logic              r_start;
    logic              r_tmo;
    logic [AGE_W-1:0]  r_age;
    logic [WAIT_W-1:0] r_wait_cnt;

    gnt_sel_t          w_winner;
    logic              w_grant;
    logic              w_ref_take;
    logic [DEBT_W-1:0] w_debt;
    logic              w_ovf;

    sdram_refresh_debt #(
        .REF_MAX (REF_MAX)
    ) u_debt (
        .i_clk     (CLK),
        .i_rst_n   (RESET),
        .i_refresh (REFRESH),
        .i_take    (w_ref_take),
        .o_debt    (w_debt),
        .o_ovf     (w_ovf)
    );

    assign w_winner = pick_winner(
        w_debt >= DEBT_W'(REF_URGENT),
        DMA_REQ && (r_age == AGE_W'(DMA_AGE)),
        CPU_REQ,
        DMA_REQ,
        w_debt != '0
    );
    assign w_grant    = (r_state == ST_IDLE) && (w_winner != SEL_NONE);
    assign w_ref_take = w_grant && (w_winner == SEL_REF);

    // Handshake: START is high for the single ISSUE cycle; the sequencer answers by
    // raising SEQ_BUSY within BUSY_TMO cycles and holds it until the access is done.
    // The grant is held from ISSUE until SEQ_BUSY falls (or the wait times out).
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= ST_IDLE;
            r_sel      <= SEL_NONE;
            r_start    <= 1'b0;
            r_tmo      <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_start <= 1'b0;
            r_tmo   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_winner != SEL_NONE) begin
                        r_sel   <= w_winner;
                        r_start <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    // The last wait cycle carries TMO_ERR, so the access is abandoned there.
                    if (r_wait_cnt == WAIT_W'(BUSY_TMO - 1)) begin
                        r_sel   <= SEL_NONE;
                        r_state <= ST_TURN;
                    end else if (SEQ_BUSY) begin
                        r_state <= ST_BUSY;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        r_tmo      <= (r_wait_cnt == WAIT_W'(BUSY_TMO - 2));
                    end
                end
                ST_BUSY: begin
                    if (!SEQ_BUSY) begin
                        r_sel   <= SEL_NONE;
                        r_state <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_sel   <= SEL_NONE;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // DMA ageing: counts CPU wins while DMA is kept waiting.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_age <= '0;
        end else if (!DMA_REQ) begin
            r_age <= '0;
        end else if (w_grant && (w_winner == SEL_DMA)) begin
            r_age <= '0;
        end else if (w_grant && (w_winner == SEL_CPU) && (r_age != AGE_W'(DMA_AGE))) begin
            r_age <= r_age + 1'b1;
        end
    end

    assign START    = r_start;
    assign TMO_ERR  = r_tmo;
    assign GNT_CPU  = (r_sel == SEL_CPU);
    assign GNT_DMA  = (r_sel == SEL_DMA);
    assign GNT_REF  = (r_sel == SEL_REF);
    assign REF_DEBT = w_debt;
    assign REF_OVF  = w_ovf;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a sequencer model answers START, a monitor checks each grant.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       REFRESH;
    logic       CPU_REQ;
    logic       DMA_REQ;
    logic       SEQ_BUSY;
    logic       START;
    logic       GNT_CPU;
    logic       GNT_DMA;
    logic       GNT_REF;
    logic [2:0] REF_DEBT;
    logic       REF_OVF;
    logic       TMO_ERR;

    logic [1:0] exp_q[$];
    int         n_vec    = 0;
    int         n_err    = 0;
    int         seq_mode = 0;  // 0 normal, 1 never busy, 2 busy stuck high
    int         busy_len = 2;
    int         glen;
    int         gap;

    sdram_arbiter dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .REFRESH  (REFRESH),
        .CPU_REQ  (CPU_REQ),
        .DMA_REQ  (DMA_REQ),
        .SEQ_BUSY (SEQ_BUSY),
        .START    (START),
        .GNT_CPU  (GNT_CPU),
        .GNT_DMA  (GNT_DMA),
        .GNT_REF  (GNT_REF),
        .REF_DEBT (REF_DEBT),
        .REF_OVF  (REF_OVF),
        .TMO_ERR  (TMO_ERR)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] obs_sel();
        case ({GNT_REF, GNT_DMA, GNT_CPU})
            3'b001:  return SEL_CPU;
            3'b010:  return SEL_DMA;
            3'b100:  return SEL_REF;
            default: return SEL_NONE;
        endcase
    endfunction

    task automatic wait_start(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (START === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_start_seen"}, seen, 1);
    endtask

    task automatic wait_idle(input string name);
        int quiet;
        quiet = 0;
        for (int i = 0; i < 400 && quiet < 4; i++) begin
            @(negedge CLK);
            if (!GNT_CPU && !GNT_DMA && !GNT_REF && !START) quiet++;
            else quiet = 0;
        end
        check({name, "_idle_reached"}, quiet >= 4, 1);
    endtask

    task automatic pulse_refresh();
        @(negedge CLK);
        REFRESH = 1'b1;
        @(negedge CLK);
        REFRESH = 1'b0;
    endtask

    task automatic cpu_grant_len(output int len);
        len = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (GNT_CPU !== 1'b1) break;
            len++;
        end
    endtask

    // Sequencer model: SEQ_BUSY rises two negedges after START and stays busy_len cycles.
    initial begin
        SEQ_BUSY = 1'b0;
        forever begin
            @(negedge CLK);
            if (seq_mode == 2) begin
                SEQ_BUSY = 1'b1;
            end else if (seq_mode == 0 && START === 1'b1 && RESET === 1'b1) begin
                repeat (2) @(negedge CLK);
                SEQ_BUSY = 1'b1;
                repeat (busy_len) @(negedge CLK);
                SEQ_BUSY = 1'b0;
            end else begin
                SEQ_BUSY = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every START pops one expected grant owner.
    initial begin
        logic [1:0] exp_v;
        logic [1:0] got_v;
        forever begin
            @(negedge CLK);
            if (RESET === 1'b1) begin
                n_vec++;
                if ($countones({GNT_REF, GNT_DMA, GNT_CPU}) > 1) begin
                    n_err++;
                    $display("FAIL grant_onehot: got grants %b, expected at most one high (t=%0t)",
                             {GNT_REF, GNT_DMA, GNT_CPU}, $time);
                end
                if (START === 1'b1) begin
                    got_v = obs_sel();
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL start_unexpected: got grant %0d, expected no START (t=%0t)",
                                 got_v, $time);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (got_v !== exp_v) begin
                            n_err++;
                            $display("FAIL grant_owner: got %0d, expected %0d (1=cpu 2=dma 3=ref, t=%0t)",
                                     got_v, exp_v, $time);
                        end
                    end
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        RESET   = 1'b0;
        REFRESH = 1'b0;
        CPU_REQ = 1'b0;
        DMA_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_start",   START,    0);
        check("rst_gnt_cpu", GNT_CPU,  0);
        check("rst_gnt_dma", GNT_DMA,  0);
        check("rst_gnt_ref", GNT_REF,  0);
        check("rst_tmo",     TMO_ERR,  0);
        check("rst_ovf",     REF_OVF,  0);
        check("rst_debt",    REF_DEBT, 1);

        // First refresh is owed straight after init
        exp_q.push_back(SEL_REF);
        RESET = 1'b1;
        #1 check("release_no_start", START, 0);
        wait_start("first_ref");
        check("debt_after_first_ref", REF_DEBT, 0);
        wait_idle("after_first_ref");

        // CPU only: 8-cycle grant, two-cycle gap, grant survives REQ drop
        busy_len = 5;
        exp_q.push_back(SEL_CPU);
        exp_q.push_back(SEL_CPU);
        CPU_REQ = 1'b1;
        wait_start("cpu1");
        cpu_grant_len(glen);
        check("cpu1_grant_len", glen, 8);
        gap = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (START === 1'b1) break;
            gap++;
        end
        check("cpu_restart_gap", gap, 2);
        CPU_REQ = 1'b0;
        cpu_grant_len(glen);
        check("cpu2_len_after_drop", glen, 8);
        wait_idle("after_cpu");

        // CPU and DMA both held: 8 CPU grants then one aged DMA grant, twice
        busy_len = 1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) exp_q.push_back(SEL_CPU);
            exp_q.push_back(SEL_DMA);
        end
        CPU_REQ = 1'b1;
        DMA_REQ = 1'b1;
        for (int i = 0; i < 18; i++) wait_start("age_run");
        CPU_REQ = 1'b0;
        DMA_REQ = 1'b0;
        wait_idle("after_age");

        // Debt reaches the urgent level and preempts a held CPU request
        busy_len = 8;
        exp_q.push_back(SEL_CPU);
        CPU_REQ = 1'b1;
        wait_start("debt_cpu1");
        repeat (3) pulse_refresh();
        check("debt_3", REF_DEBT, 3);
        exp_q.push_back(SEL_CPU);
        wait_start("debt_cpu2");
        pulse_refresh();
        check("debt_4", REF_DEBT, 4);
        exp_q.push_back(SEL_REF);
        exp_q.push_back(SEL_CPU);
        wait_start("urgent_ref");
        check("urgent_gnt_ref", GNT_REF, 1);
        check("debt_after_urgent", REF_DEBT, 3);
        wait_start("cpu_after_ref");
        CPU_REQ = 1'b0;
        repeat (3) exp_q.push_back(SEL_REF);
        wait_idle("drain");
        check("debt_drained", REF_DEBT, 0);

        // SEQ_BUSY never rises: timeout pulse in the 4th wait cycle
        seq_mode = 1;
        exp_q.push_back(SEL_CPU);
        CPU_REQ = 1'b1;
        wait_start("tmo_cpu");
        CPU_REQ = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            @(negedge CLK);
            check("tmo_pulse", TMO_ERR, (k == 5));
            check("tmo_gnt",   GNT_CPU, (k <= 5));
        end
        repeat (2) begin
            @(negedge CLK);
            check("tmo_no_restart", START, 0);
        end
        seq_mode = 0;

        // DMA grant locked by stuck SEQ_BUSY; debt saturates and overflows
        seq_mode = 2;
        repeat (2) @(negedge CLK);
        exp_q.push_back(SEL_DMA);
        DMA_REQ = 1'b1;
        wait_start("dma_lock");
        DMA_REQ = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            pulse_refresh();
            if (k == 7) begin
                check("sat_debt_7", REF_DEBT, 7);
                check("sat_no_ovf_yet", REF_OVF, 0);
            end
            if (k == 8) check("ovf_set", REF_OVF, 1);
        end
        check("sat_debt_final", REF_DEBT, 7);
        repeat (5) @(negedge CLK);
        check("ovf_sticky", REF_OVF, 1);
        check("dma_held", GNT_DMA, 1);

        // Reset in the middle of the DMA access
        #2 RESET = 1'b0;
        #1;
        check("midrst_gnt_dma", GNT_DMA,  0);
        check("midrst_start",   START,    0);
        check("midrst_ovf",     REF_OVF,  0);
        check("midrst_debt",    REF_DEBT, 1);
        seq_mode = 0;
        repeat (3) @(negedge CLK);
        exp_q.push_back(SEL_REF);
        RESET = 1'b1;
        #1 check("rerelease_no_start", START, 0);
        wait_start("post_reset_ref");
        check("post_reset_gnt_ref", GNT_REF, 1);
        wait_idle("final");
        check("final_debt", REF_DEBT, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
